demux_1n_stream: RTL
====================

Name: demux_1n_stream

Overview:
Parametrised registered 1:N demultiplexer. It is the streaming successor to the 2-output combinational demux. It routes a WIDTH-bit input word to one of CHANNELS output channels selected by in_sel, or to all channels in broadcast mode. Each output channel has a one-entry holding register with valid/ready flow control, so channels can stall independently. It sits between a single producer and N consumers on the datapath.

Parameters:
WIDTH, 8, data word width in bits (>=1)
CHANNELS, 4, number of output channels (2..16)
SEL_W, 2, select width; must equal max(1, ceil(log2(CHANNELS))); elaboration error otherwise

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous assert, active-low
in_valid  input  1  input word valid
in_ready  output  1  block accepts input this cycle (combinational)
in_data  input  WIDTH  input word
in_sel  input  SEL_W  destination channel index (unicast)
in_bcast  input  1  1 = copy word to all channels; in_sel ignored
out_valid  output  CHANNELS  per-channel holding register full
out_ready  input  CHANNELS  per-channel consumer ready
out_data  output  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
err_sel  output  1  sticky flag: a unicast word with in_sel >= CHANNELS was dropped
drop_cnt  output  8  saturating count of dropped words
err_clr  input  1  synchronous clear of err_sel and drop_cnt
idle  output  1  1 when all out_valid bits are 0

Behaviour:
- Reset (rst_n=0, asynchronous) sets out_valid=0, out_data=0 in all channels, err_sel=0, drop_cnt=0. in_ready follows its combinational equation; with all slots empty it is 1.
- Slot state: slot_free[i] = !out_valid[i] | out_ready[i].
- in_ready:
  - in_bcast=1: AND of all slot_free.
  - in_bcast=0, in_sel<CHANNELS: slot_free[in_sel].
  - in_bcast=0, in_sel>=CHANNELS: 1.
- in_ready depends combinationally on out_ready, in_sel and in_bcast. in_ready does not depend on in_valid.
- Accept = in_valid & in_ready, sampled at the rising edge.
- Unicast accept (valid in_sel): at the next edge, out_data[in_sel]<=in_data and out_valid[in_sel]<=1. Latency is 1 clock from accept to out_valid.
- Broadcast accept: every channel loads in_data and sets out_valid in the same edge. No partial broadcast ever occurs.
- Pop: out_valid[i] & out_ready[i] at an edge transfers the word. out_valid[i]<=0 unless the same channel is reloaded that edge. Simultaneous pop and load leaves out_valid[i]=1 with the new data, giving full throughput of 1 word/clock/channel.
- Non-loaded channels hold out_data unchanged. Data is never zeroed after reset.
- Invalid select (unicast, in_sel>=CHANNELS, only when CHANNELS is not a power of two): the word is accepted and discarded. No channel changes. err_sel<=1 and drop_cnt<=drop_cnt+1, saturating at 255.
- err_clr=1 clears err_sel and drop_cnt at the next edge. If a drop coincides with err_clr, the drop wins: err_sel=1, drop_cnt=1.
- idle = ~|out_valid (combinational).
- in_data, in_sel and in_bcast are don't-care when in_valid=0. Producer must hold them stable while in_valid=1 and in_ready=0.
- Reset mid-operation: all held words are lost immediately and out_valid drops asynchronously. There is no handshake obligation across reset.

Test Plan:
- Reset, then unicast in_sel=2, in_data=0xA5, all out_ready=0 -> one cycle later out_valid=4'b0100, channel 2 data=0xA5, idle=0, other channels' data=0x00.
- Channel 1 full, out_ready[1]=0; present in_sel=1 -> in_ready=0, word held off. Raise out_ready[1] with in_data=0x3C -> in_ready=1; next edge channel 1 data=0x3C, out_valid[1] stays 1.
- Broadcast in_data=0x5A with channel 3 full and stalled -> in_ready=0, no channel loads. Release channel 3 -> all four channels hold 0x5A, out_valid=4'b1111 on the same edge.
- Streaming: in_sel=0 every cycle, out_ready[0]=1, data 0x01..0x10 -> 16 words emerge on consecutive cycles in order, with no bubbles and no loss.
- CHANNELS=3, SEL_W=2: send in_sel=3 three times, then err_clr -> in_ready=1 each time, out_valid unchanged, err_sel=1, drop_cnt=3. After clear err_sel=0, drop_cnt=0. A drop on the same cycle as err_clr gives drop_cnt=1.
- 300 invalid-select drops -> drop_cnt saturates at 255. Assert rst_n=0 mid-stream with channels full -> out_valid=0 asynchronously before the next clock edge.

Source files
------------

// File: rtl/demux_1n_stream.sv
// Registered 1:N stream demultiplexer: routes one producer word to a selected
// channel (or all channels) through per-channel one-entry holding registers.
module demux_1n_stream #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_data,
   input  logic [SEL_W-1:0]          in_sel,
   input  logic                      in_bcast,
   output logic [CHANNELS-1:0]       out_valid,
   input  logic [CHANNELS-1:0]       out_ready,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic                      err_sel,
   output logic [7:0]                drop_cnt,
   input  logic                      err_clr,
   output logic                      idle
);

   localparam int SEL_W_EXP = (CHANNELS <= 2) ? 1 : $clog2(CHANNELS);

   if (SEL_W != SEL_W_EXP) begin : g_bad_sel_w
      $error("demux_1n_stream: SEL_W must equal max(1, ceil(log2(CHANNELS)))");
   end
   if (CHANNELS < 2 || CHANNELS > 16) begin : g_bad_channels
      $error("demux_1n_stream: CHANNELS must be in 2..16");
   end
   if (WIDTH < 1) begin : g_bad_width
      $error("demux_1n_stream: WIDTH must be >= 1");
   end

   logic [CHANNELS-1:0] sel_hit;
   logic [CHANNELS-1:0] slot_free;
   logic [CHANNELS-1:0] load;
   logic [CHANNELS-1:0] valid_q;
   logic [WIDTH-1:0]    data_q [CHANNELS];
   logic                sel_in_range;
   logic                accept;
   logic                drop;
   logic                err_q;
   logic [7:0]          cnt_q;

   // Handshake: a word transfers on any rising edge where valid and ready are
   // both 1; ready never looks at valid, and a stalled producer holds its word.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      assign sel_hit[i]                    = (in_sel == SEL_W'(i));
      assign out_data[i*WIDTH +: WIDTH]    = data_q[i];
   end

   assign sel_in_range = |sel_hit;
   assign slot_free    = ~valid_q | out_ready;

   always_comb begin
      in_ready = 1'b1;
      if (in_bcast)
         in_ready = &slot_free;
      else if (sel_in_range)
         in_ready = |(sel_hit & slot_free);
   end

   assign accept = in_valid & in_ready;
   assign load   = {CHANNELS{accept}} & (in_bcast ? {CHANNELS{1'b1}} : sel_hit);
   // Out-of-range unicast selects are swallowed so the producer never deadlocks.
   assign drop   = accept & ~in_bcast & ~sel_in_range;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int i = 0; i < CHANNELS; i++) data_q[i] <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (load[i]) begin
               valid_q[i] <= 1'b1;
               data_q[i]  <= in_data;
            end else if (out_ready[i]) begin
               valid_q[i] <= 1'b0;
            end
         end
      end
   end

   // A drop in the same cycle as a clear counts as the first new drop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
         cnt_q <= '0;
      end else if (drop) begin
         err_q <= 1'b1;
         if (err_clr)
            cnt_q <= 8'd1;
         else if (cnt_q != 8'hFF)
            cnt_q <= cnt_q + 8'd1;
      end else if (err_clr) begin
         err_q <= 1'b0;
         cnt_q <= '0;
      end
   end

   assign out_valid = valid_q;
   assign err_sel   = err_q;
   assign drop_cnt  = cnt_q;
   assign idle      = ~|valid_q;

endmodule
